if_fetch_stage: RTL

- Instruction-fetch stage of the CPU. Owns the program counter and drives the instruction-memory address.
- Latches the fetched word into the IF/ID pipeline register, which the decode/execute logic consumes.
- Resolves unconditional jumps (opcode 6'b000010) locally.
- Accepts stall and redirect requests from downstream.

---
 rtl/if_fetch_stage_if.sv | 44 ++++
 rtl/if_fetch_stage.sv | 70 +++++++
 2 files changed

// File: rtl/if_fetch_stage_if.sv
// Bundle of the fetch stage's memory, control and IF/ID signals.
// The master side is the fetch stage itself; the slave side is the
// surrounding core (instruction memory, hazard unit and decode).
interface if_fetch_stage_if;
    logic        start;
    logic [31:0] i_datain;
    logic        stall;
    logic        redirect_valid;
    logic [31:0] redirect_target;
    logic [31:0] i_addr;
    logic [31:0] pc;
    logic [31:0] if_id_instr;
    logic [31:0] if_id_pc4;
    logic        if_id_valid;
    logic [15:0] bubble_count;

    modport master (
        input  start,
        input  i_datain,
        input  stall,
        input  redirect_valid,
        input  redirect_target,
        output i_addr,
        output pc,
        output if_id_instr,
        output if_id_pc4,
        output if_id_valid,
        output bubble_count
    );

    modport slave (
        output start,
        output i_datain,
        output stall,
        output redirect_valid,
        output redirect_target,
        input  i_addr,
        input  pc,
        input  if_id_instr,
        input  if_id_pc4,
        input  if_id_valid,
        input  bubble_count
    );
endinterface

// File: rtl/if_fetch_stage.sv
// Instruction-fetch stage: owns the PC, addresses instruction memory,
// resolves unconditional jumps locally and fills the IF/ID register.
// Downstream can stall the stage or redirect it; a redirect wins over
// a stall, and reset wins over everything.
module if_fetch_stage #(
    parameter logic [31:0] RESET_PC    = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR   = 32'h0000_0000,
    parameter logic [5:0]  JUMP_OPCODE = 6'b000010
) (
    input  logic              clock,
    input  logic              reset,
    if_fetch_stage_if.master  bus
);

    logic [31:0] pc_q;
    logic [31:0] instr_q;
    logic [31:0] pc4_q;
    logic        valid_q;
    logic [15:0] bubble_q;

    logic [31:0] pc4;
    logic [31:0] jump_target;
    logic        is_jump;
    logic [15:0] bubble_next;

    assign pc4         = pc_q + 32'd4;
    assign is_jump     = (bus.i_datain[31:26] == JUMP_OPCODE);
    assign jump_target = {pc4[31:28], bus.i_datain[25:0], 2'b00};
    assign bubble_next = (bubble_q == 16'hFFFF) ? bubble_q : bubble_q + 16'd1;

    assign bus.i_addr       = pc_q;
    assign bus.pc           = pc_q;
    assign bus.if_id_instr  = instr_q;
    assign bus.if_id_pc4    = pc4_q;
    assign bus.if_id_valid  = valid_q;
    assign bus.bubble_count = bubble_q;

    // PC and IF/ID update with priority reset > redirect > stall > idle > fetch.
    always_ff @(posedge clock) begin
        if (reset) begin
            pc_q     <= RESET_PC;
            instr_q  <= NOP_INSTR;
            pc4_q    <= 32'd0;
            valid_q  <= 1'b0;
            bubble_q <= 16'd0;
        end else if (bus.redirect_valid) begin
            pc_q     <= {bus.redirect_target[31:2], 2'b00};
            instr_q  <= NOP_INSTR;
            pc4_q    <= 32'd0;
            valid_q  <= 1'b0;
            bubble_q <= bubble_next;
        end else if (bus.stall) begin
            pc_q     <= pc_q;
            instr_q  <= instr_q;
            pc4_q    <= pc4_q;
            valid_q  <= valid_q;
            bubble_q <= bubble_q;
        end else if (!bus.start) begin
            instr_q  <= NOP_INSTR;
            valid_q  <= 1'b0;
            bubble_q <= bubble_next;
        end else begin
            instr_q  <= bus.i_datain;
            pc4_q    <= pc4;
            valid_q  <= 1'b1;
            pc_q     <= is_jump ? jump_target : pc4;
        end
    end

endmodule
